// File: rtl/synchronizer.sv
// Router synchronizer: latches the packet destination, steers the FIFO write enable and full flag,
// and (with SOFT_RESET_EN defined) flushes any FIFO whose data sits unread for TIMEOUT cycles.
module synchronizer #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    logic [1:0] addr_q;
    logic [1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (detect_add) begin
            addr_d = data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= 2'b00;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Address 11 is not a FIFO, so it must neither write nor report full.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            2'b00: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'b01: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'b10: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

`ifdef SOFT_RESET_EN
    localparam logic [4:0] LAST_COUNT = 5'(TIMEOUT - 1);

    logic [2:0] vldVec;
    logic [2:0] readVec;
    logic [4:0] stallCount_q [3];
    logic [4:0] stallCount_d [3];
    logic [2:0] softReset_q;
    logic [2:0] softReset_d;

    assign vldVec  = {vld_out_2, vld_out_1, vld_out_0};
    assign readVec = {read_enb_2, read_enb_1, read_enb_0};

    // Each FIFO counts its own unread-data cycles; a timeout restarts the count so a
    // persistent stall keeps pulsing every TIMEOUT cycles.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            stallCount_d[n] = stallCount_q[n];
            softReset_d[n]  = 1'b0;
            if (!vldVec[n]) begin
                stallCount_d[n] = 5'd0;
            end else if (readVec[n]) begin
                stallCount_d[n] = 5'd0;
            end else if (stallCount_q[n] == LAST_COUNT) begin
                stallCount_d[n] = 5'd0;
                softReset_d[n]  = 1'b1;
            end else begin
                stallCount_d[n] = stallCount_q[n] + 5'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int n = 0; n < 3; n++) begin
                stallCount_q[n] <= 5'd0;
            end
            softReset_q <= 3'b000;
        end else begin
            for (int n = 0; n < 3; n++) begin
                stallCount_q[n] <= stallCount_d[n];
            end
            softReset_q <= softReset_d;
        end
    end

    assign soft_reset_0 = softReset_q[0];
    assign soft_reset_1 = softReset_q[1];
    assign soft_reset_2 = softReset_q[2];
`else
    localparam int unusedTimeout = TIMEOUT;
    logic unusedReadEnb;

    assign unusedReadEnb = read_enb_0 ^ read_enb_1 ^ read_enb_2;
    assign soft_reset_0  = 1'b0;
    assign soft_reset_1  = 1'b0;
    assign soft_reset_2  = 1'b0;
`endif

endmodule

// File: tb/tb_synchronizer.sv
// Scoreboard bench for synchronizer: expectations are queued as stimulus is applied and
// popped as each output is sampled. Pulse expectations follow SOFT_RESET_EN.
module tb_synchronizer;

    localparam int TIMEOUT = 30;
`ifdef SOFT_RESET_EN
    localparam bit SR_EN = 1'b1;
`else
    localparam bit SR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       detect_add = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       write_enb_reg = 1'b0;
    logic [2:0] readVec = 3'b000;
    logic [2:0] emptyVec = 3'b111;
    logic [2:0] fullVec = 3'b000;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    typedef struct {
        string      tag;
        logic [3:0] value;
    } expItem_t;

    expItem_t expQueue[$];
    int checkCount = 0;
    int errorCount = 0;

    synchronizer #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb_0(readVec[0]), .read_enb_1(readVec[1]), .read_enb_2(readVec[2]),
        .empty_0(emptyVec[0]), .empty_1(emptyVec[1]), .empty_2(emptyVec[2]),
        .full_0(fullVec[0]), .full_1(fullVec[1]), .full_2(fullVec[2]),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .write_enb(write_enb), .fifo_full(fifo_full),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushExpected(input string tag, input logic [3:0] value);
        expItem_t item;
        item.tag   = tag;
        item.value = value;
        expQueue.push_back(item);
    endtask

    task automatic compareNext(input logic [3:0] observed);
        expItem_t item;
        if (expQueue.size() == 0) begin
            checkOutput("scoreboard_empty", 4'h1, 4'h0);
        end else begin
            item = expQueue.pop_front();
            checkOutput(item.tag, observed, item.value);
        end
    endtask

    function automatic logic [3:0] softResets();
        return {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    endfunction

    function automatic logic [3:0] vldOuts();
        return {1'b0, vld_out_2, vld_out_1, vld_out_0};
    endfunction

    // Queue the soft-reset vector for the next 'edges' edges of a fresh stall on FIFO n.
    task automatic pushStall(input int n, input int edges, input string tag);
        for (int k = 1; k <= edges; k++) begin
            if (SR_EN && (k % TIMEOUT == 0)) pushExpected(tag, 4'(1 << n));
            else pushExpected(tag, 4'h0);
        end
    endtask

    task automatic clockAndCompare(input int edges);
        for (int k = 0; k < edges; k++) begin
            @(posedge clock);
            #1;
            compareNext(softResets());
        end
    endtask

    task automatic applyStimulus(input logic da, input logic [1:0] din);
        @(negedge clock);
        detect_add = da;
        data_in    = din;
        @(negedge clock);
        detect_add = 1'b0;
    endtask

    initial begin
        // Reset state; combinational paths must still follow inputs.
        #1;
        write_enb_reg = 1'b1;
        emptyVec      = 3'b101;
        #1;
        pushExpected("reset_soft", 4'h0);      compareNext(softResets());
        pushExpected("reset_wenb", 4'h1);      compareNext({1'b0, write_enb});
        pushExpected("reset_vld", 4'h2);       compareNext(vldOuts());
        emptyVec      = 3'b111;
        write_enb_reg = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        // Address 01 steering and hold when detect_add is low.
        applyStimulus(1'b1, 2'b01);
        write_enb_reg = 1'b1;
        #1;
        pushExpected("addr1_wenb", 4'h2);      compareNext({1'b0, write_enb});
        pushExpected("addr1_full0", 4'h0);     compareNext({3'b0, fifo_full});
        fullVec = 3'b010;
        #1;
        pushExpected("addr1_full1", 4'h1);     compareNext({3'b0, fifo_full});
        data_in = 2'b11;
        @(posedge clock);
        #1;
        pushExpected("addr1_hold", 4'h2);      compareNext({1'b0, write_enb});
        write_enb_reg = 1'b0;
        #1;
        pushExpected("addr1_wreg0", 4'h0);     compareNext({1'b0, write_enb});

        // Every valid address with its own FIFO full, then with all others full.
        for (int a = 0; a < 3; a++) begin
            applyStimulus(1'b1, 2'(a));
            write_enb_reg = 1'b1;
            fullVec = 3'(1 << a);
            #1;
            pushExpected("addr_wenb", 4'(1 << a)); compareNext({1'b0, write_enb});
            pushExpected("addr_full", 4'h1);       compareNext({3'b0, fifo_full});
            fullVec = ~3'(1 << a);
            #1;
            pushExpected("addr_nfull", 4'h0);      compareNext({3'b0, fifo_full});
        end

        // Invalid address 11.
        applyStimulus(1'b1, 2'b11);
        fullVec = 3'b111;
        #1;
        pushExpected("addr3_wenb", 4'h0);      compareNext({1'b0, write_enb});
        pushExpected("addr3_full", 4'h0);      compareNext({3'b0, fifo_full});
        write_enb_reg = 1'b0;
        fullVec = 3'b000;

        // FIFO 0 persistent stall: pulses at edges 30, 60, 90.
        @(negedge clock);
        emptyVec[0] = 1'b0;
        #1;
        pushExpected("vld0", 4'h1);            compareNext(vldOuts());
        pushStall(0, 100, "stall0");
        clockAndCompare(100);
        @(negedge clock);
        emptyVec[0] = 1'b1;
        @(negedge clock);

        // FIFO 1: a read after 20 stalled edges restarts the count.
        emptyVec[1] = 1'b0;
        pushStall(1, 20, "stall1_pre");
        clockAndCompare(20);
        @(negedge clock);
        readVec[1] = 1'b1;
        pushExpected("stall1_read", 4'h0);
        clockAndCompare(1);
        @(negedge clock);
        readVec[1] = 1'b0;
        pushStall(1, 35, "stall1_post");
        clockAndCompare(35);
        @(negedge clock);
        emptyVec[1] = 1'b1;

        // FIFO 2: asynchronous reset mid-stall clears address and counter.
        applyStimulus(1'b1, 2'b10);
        write_enb_reg = 1'b1;
        emptyVec[2]   = 1'b0;
        pushStall(2, 15, "stall2_pre");
        clockAndCompare(15);
        #2;
        resetn = 1'b0;
        #1;
        pushExpected("areset_soft", 4'h0);     compareNext(softResets());
        pushExpected("areset_wenb", 4'h1);     compareNext({1'b0, write_enb});
        pushExpected("areset_vld", 4'h4);      compareNext(vldOuts());
        @(negedge clock);
        resetn = 1'b1;
        write_enb_reg = 1'b0;
        pushStall(2, 35, "stall2_post");
        clockAndCompare(35);
        @(negedge clock);
        emptyVec[2] = 1'b1;
        @(negedge clock);

        // Asynchronous reset must clear a pulse that is currently high.
        emptyVec[0] = 1'b0;
        pushStall(0, TIMEOUT, "stall0_again");
        clockAndCompare(TIMEOUT);
        #2;
        resetn = 1'b0;
        #1;
        pushExpected("areset_pulse", 4'h0);    compareNext(softResets());
        @(negedge clock);
        resetn = 1'b1;
        emptyVec[0] = 1'b1;

        if (expQueue.size() != 0) checkOutput("scoreboard_left", 4'(expQueue.size()), 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
